fifo_stream_sync: RTL
=====================

// Module: fifo_stream_sync
// PURPOSE
//   Single-clock, parametrised stream FIFO with a valid/ready interface on both sides.
//   Successor to the dual-clock stream FIFO, for intra-domain links between operator pages.
//   Adds: true backpressure on input, registered output stage with bypass, occupancy count,
//   almost-full flag, synchronous flush and a sticky overflow flag.
// PARAMETERS
//   PAYLOAD_BITS  32  data width in bits
//   ADDR_BITS     9   DEPTH = 2**ADDR_BITS total entries, output register included; ADDR_BITS >= 1
//   AF_THRESH     DEPTH-2  almost_full asserts when count >= AF_THRESH; 1 <= AF_THRESH <= DEPTH
// PORTS
//   clk             in   1             clock, all logic on rising edge
//   reset           in   1             asynchronous, active-high reset
//   flush           in   1             synchronous clear of contents
//   din             in   PAYLOAD_BITS  input data
//   val_in          in   1             input valid
//   ready_upward    out  1             input ready (= !full)
//   dout            out  PAYLOAD_BITS  output data, registered
//   val_out         out  1             output valid, registered
//   ready_downward  in   1             downstream ready
//   count           out  ADDR_BITS+1   occupancy 0..DEPTH, registered
//   almost_full     out  1             count >= AF_THRESH
//   overflow        out  1             sticky: write attempted while full
// BEHAVIOUR
//   - Reset (async, active-high): count=0, pointers=0, val_out=0, dout=0, overflow=0.
//     ready_upward=1 and almost_full=0 once reset clears.
//     Reset mid-operation discards all contents immediately.
//   - push = val_in & ready_upward; pop = val_out & ready_downward.
//   - full = (count == DEPTH); ready_upward = !full. It depends on the registered count only,
//     never on ready_downward: at full, a same-cycle push is rejected even when pop=1.
//   - count_next = count + push - pop. Count includes the output register.
//   - Storage: memory with combinational read, DEPTH-1 entries used as a ring (wr_ptr, rd_ptr).
//     mem_cnt = count - val_out. Pointers wrap modulo DEPTH-1.
//   - Output stage FSM, state = val_out:
//     * EMPTY (val_out=0): push loads din straight into dout (bypass) -> VALID next cycle.
//       First-word latency is 1 cycle. No push -> stay EMPTY.
//     * VALID (val_out=1) with !ready_downward: hold; dout and val_out stay stable.
//     * VALID with pop:
//       - mem_cnt>0: dout <= mem[rd_ptr], rd_ptr++, stay VALID.
//       - mem_cnt==0 and push: dout <= din (bypass), stay VALID.
//       - otherwise: val_out <= 0, dout <= 0, go to EMPTY.
//   - A push not bypassed writes mem[wr_ptr], wr_ptr++. When the output stage loads from
//     memory in the same cycle, the push always goes to memory, so FIFO order is preserved.
//   - Sustained push+pop gives 1 word/cycle at any 0 < count < DEPTH.
//   - almost_full: combinational from registered count.
//   - overflow: set when val_in & full & !flush. Cleared only by reset or flush.
//     The rejected word is dropped.
//   - flush: highest priority after reset. Next cycle: count=0, pointers=0, val_out=0, dout=0,
//     overflow=0. A push or pop in the flush cycle has no effect.
//   - dout is 0 whenever val_out=0.
// TESTING  (PAYLOAD_BITS=32, ADDR_BITS=2 -> DEPTH=4, AF_THRESH=3)
//   1. Empty, ready_downward=1, single write 0xA5 -> next cycle val_out=1, dout=0xA5, count=1;
//      following cycle val_out=0, dout=0, count=0.
//   2. ready_downward=0, val_in=1 with 1,2,3,4,5 on consecutive cycles -> 1..4 accepted;
//      almost_full=1 after the 3rd; ready_upward=0 after the 4th; 5 dropped; overflow=1; count=4.
//      Then ready_downward=1 -> dout 1,2,3,4 on consecutive cycles, then val_out=0.
//   3. Backpressure: dout=0x11 valid, ready_downward=0 for 5 cycles while writing 0x22,0x33
//      -> dout stays 0x11, val_out stays 1, count=3; release -> 0x11,0x22,0x33 in order.
//   4. Streaming: pre-load 2 words, then push+pop every cycle for 100 words
//      -> count stays 2, zero bubbles, output sequence equals input sequence.
//   5. At count=3 with overflow=1, assert flush with val_in=1, din=0x77 -> next cycle count=0,
//      val_out=0, overflow=0, ready_upward=1; 0x77 never appears on dout.
//   6. At count=3, assert reset asynchronously mid-cycle -> val_out=0, dout=0, count=0
//      before the next clock edge; after release, write 0x5 -> dout=0x5 one cycle later.

Source files
------------

// File: rtl/fifo_stream_sync.sv
// Single-clock stream FIFO with valid/ready on both sides, a registered output
// stage with bypass, occupancy count, almost-full and a sticky overflow flag.
module fifo_stream_sync #(
    parameter int PAYLOAD_BITS = 32,
    parameter int ADDR_BITS    = 9,
    parameter int AF_THRESH    = (2 ** ADDR_BITS) - 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [PAYLOAD_BITS-1:0] din,
    input  logic                    val_in,
    output logic                    ready_upward,
    output logic [PAYLOAD_BITS-1:0] dout,
    output logic                    val_out,
    input  logic                    ready_downward,
    output logic [ADDR_BITS:0]      count,
    output logic                    almost_full,
    output logic                    overflow
);

    localparam int DEPTH        = 2 ** ADDR_BITS;
    localparam int MEM_ENTRIES  = DEPTH - 1;
    localparam int PTR_LAST_INT = DEPTH - 2;
    localparam int ONE_INT      = 1;

    localparam logic [ADDR_BITS:0]   C_DEPTH    = DEPTH[ADDR_BITS:0];
    localparam logic [ADDR_BITS:0]   C_AF       = AF_THRESH[ADDR_BITS:0];
    localparam logic [ADDR_BITS:0]   C_CNT_ONE  = ONE_INT[ADDR_BITS:0];
    localparam logic [ADDR_BITS-1:0] C_PTR_ONE  = ONE_INT[ADDR_BITS-1:0];
    localparam logic [ADDR_BITS-1:0] C_PTR_LAST = PTR_LAST_INT[ADDR_BITS-1:0];

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_VALID = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [PAYLOAD_BITS-1:0] r_dout;
    logic [PAYLOAD_BITS-1:0] w_dout_next;
    logic [ADDR_BITS:0]      r_count;
    logic [ADDR_BITS:0]      w_count_next;
    logic [ADDR_BITS-1:0]    r_wr_ptr;
    logic [ADDR_BITS-1:0]    r_rd_ptr;
    logic                    r_overflow;
    logic [PAYLOAD_BITS-1:0] r_mem [MEM_ENTRIES];

    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_val_out;
    logic w_mem_empty;
    logic w_mem_wr;
    logic w_rd_adv;

    // Ring pointers step through DEPTH-1 slots; the output register is the extra entry.
    function automatic logic [ADDR_BITS-1:0] ptr_inc(input logic [ADDR_BITS-1:0] p);
        logic [ADDR_BITS-1:0] n;
        if (p == C_PTR_LAST) begin
            n = '0;
        end else begin
            n = p + C_PTR_ONE;
        end
        return n;
    endfunction

    assign w_val_out    = (r_state == ST_VALID);
    assign w_full       = (r_count == C_DEPTH);
    assign w_push       = val_in & ~w_full;
    assign w_pop        = w_val_out & ready_downward;
    assign w_mem_empty  = (r_count == {{ADDR_BITS{1'b0}}, w_val_out});

    assign ready_upward = ~w_full;
    assign almost_full  = (r_count >= C_AF);
    assign val_out      = w_val_out;
    assign dout         = r_dout;
    assign count        = r_count;
    assign overflow     = r_overflow;

    // Output-stage next state, output data and memory read/write strobes.
    always_comb begin
        w_state_next = r_state;
        w_dout_next  = r_dout;
        w_mem_wr     = 1'b0;
        w_rd_adv     = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_push) begin
                    w_state_next = ST_VALID;
                    w_dout_next  = din;
                end else begin
                    w_state_next = ST_EMPTY;
                end
            end
            ST_VALID: begin
                if (!w_pop) begin
                    w_mem_wr = w_push;
                end else if (!w_mem_empty) begin
                    // Loading from memory: any concurrent push queues behind it.
                    w_dout_next = r_mem[r_rd_ptr];
                    w_rd_adv    = 1'b1;
                    w_mem_wr    = w_push;
                end else if (w_push) begin
                    w_dout_next = din;
                end else begin
                    w_state_next = ST_EMPTY;
                    w_dout_next  = '0;
                end
            end
            default: begin
                w_state_next = ST_EMPTY;
                w_dout_next  = '0;
            end
        endcase
    end

    // Occupancy bookkeeping.
    always_comb begin
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + C_CNT_ONE;
            2'b01:   w_count_next = r_count - C_CNT_ONE;
            default: w_count_next = r_count;
        endcase
    end

    // Control state, output register, pointers and sticky overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_EMPTY;
            r_dout     <= '0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else if (flush) begin
            r_state    <= ST_EMPTY;
            r_dout     <= '0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_dout     <= w_dout_next;
            r_count    <= w_count_next;
            r_wr_ptr   <= w_mem_wr ? ptr_inc(r_wr_ptr) : r_wr_ptr;
            r_rd_ptr   <= w_rd_adv ? ptr_inc(r_rd_ptr) : r_rd_ptr;
            r_overflow <= r_overflow | (val_in & w_full);
        end
    end

    // Storage array; contents are meaningless outside the pointer window, so no reset.
    always_ff @(posedge clk) begin
        if (w_mem_wr && !flush) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

endmodule
